cnfg_sr_ctrl: RTL

CNFG_SR_CTRL -- requirements
Module: cnfg_sr_ctrl

---
 rtl/cnfg_sr_pkg.sv | 16 +
 rtl/cnfg_sr_tick.sv | 45 ++++
 rtl/cnfg_sr_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/cnfg_sr_pkg.sv
// Shared types and default sizing for the configuration shift-register controller.
// Readback logic elsewhere is enabled by defining CNFG_SR_READBACK_EN.
package cnfg_sr_pkg;

   localparam int SR_LEN_DEF   = 64;
   localparam int CLK_DIV_DEF  = 2;
   localparam int LD_WIDTH_DEF = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LOAD  = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/cnfg_sr_tick.sv
// Phase timing for the chain clock: counts CLK_DIV cycles per sr_clk phase and
// strobes the last cycle of each low and high phase.
module cnfg_sr_tick #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   input  logic clr,
   output logic phase,
   output logic low_end,
   output logic high_end
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] cnt;
   logic          ph;
   logic          last;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
         ph  <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
         ph  <= 1'b0;
      end else if (en) begin
         if (cnt == LAST) begin
            cnt <= '0;
            ph  <= ~ph;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // A clear in the same cycle suppresses the strobes so an abort never advances a slot.
   assign last     = en && !clr && (cnt == LAST);
   assign phase    = ph;
   assign low_end  = last && !ph;
   assign high_end = last && ph;

endmodule

// File: rtl/cnfg_sr_ctrl.sv
// Serial configuration-chain programmer: shifts a word out MSB first, pulses the
// latch enable, then reports done. CNFG_SR_READBACK_EN adds capture of the old chain contents.
module cnfg_sr_ctrl
   import cnfg_sr_pkg::*;
#(
   parameter int SR_LEN   = SR_LEN_DEF,
   parameter int CLK_DIV  = CLK_DIV_DEF,
   parameter int LD_WIDTH = LD_WIDTH_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              abort,
   input  logic [SR_LEN-1:0] data,
   output logic              busy,
   output logic              done,
   output logic              sr_clk,
   output logic              sr_si,
   output logic              sr_ld,
   input  logic              sr_so
`ifdef CNFG_SR_READBACK_EN
   ,
   output logic [SR_LEN-1:0] rb_data
`endif
);

   localparam int BW = $clog2(SR_LEN + 1);
   localparam int LW = (LD_WIDTH > 1) ? $clog2(LD_WIDTH) : 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(SR_LEN - 1);
   localparam logic [LW-1:0] LD_LAST  = LW'(LD_WIDTH - 1);

   state_t            state_q;
   state_t            state_d;
   logic [BW-1:0]     bit_cnt;
   logic [LW-1:0]     ld_cnt;
   logic [SR_LEN-1:0] shadow;
   logic              shifting;
   logic              accept;
   logic              tick_clr;
   logic              phase;
   logic              low_end;
   logic              high_end;

   assign shifting = (state_q == SHIFT);
   assign accept   = (state_q == IDLE) && start && !abort;
   assign tick_clr = abort || !shifting;

   cnfg_sr_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (shifting),
      .clr      (tick_clr),
      .phase    (phase),
      .low_end  (low_end),
      .high_end (high_end)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = SHIFT;
         end
         SHIFT: begin
            if (abort)                                  state_d = IDLE;
            else if (high_end && (bit_cnt == BIT_LAST)) state_d = LOAD;
         end
         LOAD: begin
            if (abort)                  state_d = IDLE;
            else if (ld_cnt == LD_LAST) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Counters restart from zero on every exit from their state, so they cannot wrap mid-transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt <= '0;
      end else if (!shifting || abort) begin
         bit_cnt <= '0;
      end else if (high_end) begin
         bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ld_cnt <= '0;
      end else if ((state_q != LOAD) || abort) begin
         ld_cnt <= '0;
      end else if (ld_cnt != LD_LAST) begin
         ld_cnt <= ld_cnt + LW'(1);
      end
   end

   // Shadow advances at the end of the high phase, i.e. together with the sr_clk fall.
   always_ff @(posedge clk) begin
      if (accept) begin
         shadow <= data;
      end else if (shifting && high_end) begin
         shadow <= {shadow[SR_LEN-2:0], 1'b0};
      end
   end

   assign busy   = (state_q != IDLE);
   assign done   = (state_q == DONE);
   assign sr_ld  = (state_q == LOAD);
   assign sr_clk = shifting && phase;
   assign sr_si  = shifting && shadow[SR_LEN-1];

`ifdef CNFG_SR_READBACK_EN
   logic [SR_LEN-1:0] rb_sr;

   // Sampled just before the rising edge, so the first bit captured is the chain's old MSB.
   always_ff @(posedge clk) begin
      if (low_end) rb_sr <= {rb_sr[SR_LEN-2:0], sr_so};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               rb_data <= '0;
      else if (state_q == DONE) rb_data <= rb_sr;
   end
`else
   logic unused_so;
   assign unused_so = sr_so;
`endif

endmodule
